// File: rtl/dma_desc_pkg.sv
// Shared definitions for the DMA read-descriptor path.
// Holds the 28-bit descriptor field layout, the 4 KB (1024-DW) boundary,
// the reader FSM state type and a helper that expands the length field.
// No ports (package).
package dma_desc_pkg;

    localparam int DESC_W      = 28;
    localparam int TAG_LSB     = 24;
    localparam int TAG_W       = 4;
    localparam int LEN_LSB     = 14;
    localparam int LEN_W       = 10;
    localparam int ADDR_LSB    = 0;
    localparam int ADDR_W      = 14;
    localparam int REM_W       = 11;   // holds 1..1024
    localparam int BOUNDARY_DW = 1024;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } rd_state_e;

    // A length field of zero stands for a full 1024-DW transfer.
    function automatic logic [REM_W-1:0] expand_len(input logic [LEN_W-1:0] len);
        logic [REM_W-1:0] res;
        if (len == 10'd0) begin
            res = 11'd1024;
        end else begin
            res = {1'b0, len};
        end
        return res;
    endfunction

endpackage

// File: rtl/desc_chunk_calc.sv
// Combinational request sizer.
// Given the current DW address and the DW still to transfer, returns the
// next request length: the smallest of the remaining length, the maximum
// payload and the distance to the next 1024-DW boundary.
// Ports:
//   addr_i   [13:0] current DW address
//   rem_i    [10:0] DW remaining in the descriptor (1..1024)
//   chunk_o  [10:0] length of the next request
//   last_o          the next request finishes the descriptor
module desc_chunk_calc
    import dma_desc_pkg::*;
#(
    parameter int MAX_PAYLOAD_DW = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [REM_W-1:0]  rem_i,
    output logic [REM_W-1:0]  chunk_o,
    output logic              last_o
);

    localparam logic [REM_W-1:0] MAX_S = REM_W'(MAX_PAYLOAD_DW);
    localparam logic [REM_W-1:0] BND_S = REM_W'(BOUNDARY_DW);

    logic [REM_W-1:0] to_bnd_s;
    logic [REM_W-1:0] lim_s;

    // DW left before the address crosses into the next 4 KB page.
    assign to_bnd_s = BND_S - {1'b0, addr_i[9:0]};
    assign lim_s    = (rem_i < MAX_S) ? rem_i : MAX_S;
    assign chunk_o  = (to_bnd_s < lim_s) ? to_bnd_s : lim_s;
    assign last_o   = (chunk_o == rem_i);

endmodule

// File: rtl/fifo_desc_reader.sv
// Pop-side consumer of the DMA read-descriptor FIFO.
// Pops one descriptor at a time and splits it into read requests that never
// exceed MAX_PAYLOAD_DW and never cross a 1024-DW boundary. Requests leave on
// a valid/ready interface with registered outputs.
// Ports:
//   clockCore, resetCore (sync, active low)
//   enable              allow new pops
//   fifoEmpty, fifoData show-ahead FIFO head; fifoPop removes it
//   reqValid/reqReady   request handshake
//   reqAddr, reqLen, reqTag, reqLast   request fields (reqLen 0 = 1024)
//   busy                a descriptor is in progress
//   descDone            completed-descriptor counter (wraps)
module fifo_desc_reader
    import dma_desc_pkg::*;
#(
    parameter int MAX_PAYLOAD_DW = 32,
    parameter int CNT_W          = 16
) (
    input  logic               clockCore,
    input  logic               resetCore,
    input  logic               enable,
    input  logic               fifoEmpty,
    input  logic [27:0]        fifoData,
    output logic               fifoPop,
    output logic               reqValid,
    input  logic               reqReady,
    output logic [13:0]        reqAddr,
    output logic [9:0]         reqLen,
    output logic [3:0]         reqTag,
    output logic               reqLast,
    output logic               busy,
    output logic [CNT_W-1:0]   descDone
);

    rd_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [REM_W-1:0]   chunk_q, chunk_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   done_q, done_d;

    logic               can_pop_s;
    logic               pop_s;
    logic               upd_s;
    logic [REM_W-1:0]   chunk_s;
    logic               last_s;

    // Sized from the next-state address/remaining so the registered request
    // fields are ready the cycle after a load or handshake.
    desc_chunk_calc #(
        .MAX_PAYLOAD_DW (MAX_PAYLOAD_DW)
    ) u_chunk (
        .addr_i  (addr_d),
        .rem_i   (rem_d),
        .chunk_o (chunk_s),
        .last_o  (last_s)
    );

    assign can_pop_s = enable & ~fifoEmpty & resetCore;

    // Next-state logic: pop decisions, descriptor load and address advance.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        tag_d   = tag_q;
        done_d  = done_q;
        pop_s   = 1'b0;
        upd_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (can_pop_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (reqReady) begin
                    if (last_q) begin
                        done_d = done_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        // Chain straight into the next descriptor with no bubble.
                        if (can_pop_s) begin
                            pop_s   = 1'b1;
                            state_d = ST_ISSUE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // 14-bit add wraps the DW address silently.
                        addr_d = addr_q + {3'd0, chunk_q};
                        rem_d  = rem_q - chunk_q;
                        upd_s  = 1'b1;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (pop_s) begin
            tag_d  = fifoData[TAG_LSB +: TAG_W];
            addr_d = fifoData[ADDR_LSB +: ADDR_W];
            rem_d  = expand_len(fifoData[LEN_LSB +: LEN_W]);
            upd_s  = 1'b1;
        end else begin
            tag_d  = tag_d;
        end
    end

    // Request length/last only change when a new request is formed.
    always_comb begin
        chunk_d = chunk_q;
        last_d  = last_q;
        if (upd_s) begin
            chunk_d = chunk_s;
            last_d  = last_s;
        end else begin
            chunk_d = chunk_q;
            last_d  = last_q;
        end
    end

    // State and request registers with synchronous active-low reset.
    always_ff @(posedge clockCore) begin
        if (!resetCore) begin
            state_q <= ST_IDLE;
            addr_q  <= 14'd0;
            rem_q   <= 11'd0;
            tag_q   <= 4'd0;
            chunk_q <= 11'd0;
            last_q  <= 1'b0;
            done_q  <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
            chunk_q <= chunk_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign fifoPop  = pop_s;
    assign reqValid = (state_q == ST_ISSUE);
    assign busy     = (state_q == ST_ISSUE);
    assign reqAddr  = addr_q;
    assign reqLen   = chunk_q[9:0];
    assign reqTag   = tag_q;
    assign reqLast  = last_q;
    assign descDone = done_q;

endmodule

// File: tb/tb_fifo_desc_reader.sv
// Self-checking bench for fifo_desc_reader: a queue-based FIFO model, a
// descriptor-splitting reference model, table-driven directed descriptors,
// hand-written corner sequences and a randomized run.
module tb_fifo_desc_reader;

    localparam int MP  = 32;
    localparam int MP2 = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetCore, enable, fifoEmpty, fifoPop, reqValid, reqReady;
    logic [27:0] fifoData;
    logic [13:0] reqAddr;
    logic [9:0]  reqLen;
    logic [3:0]  reqTag;
    logic        reqLast, busy;
    logic [15:0] descDone;

    logic        enable2, fifoEmpty2, fifoPop2, reqValid2, reqReady2;
    logic [27:0] fifoData2;
    logic [13:0] reqAddr2;
    logic [9:0]  reqLen2;
    logic [3:0]  reqTag2;
    logic        reqLast2, busy2;
    logic [15:0] descDone2;

    fifo_desc_reader #(.MAX_PAYLOAD_DW(MP), .CNT_W(16)) u_dut (
        .clockCore(clk), .resetCore(resetCore), .enable(enable),
        .fifoEmpty(fifoEmpty), .fifoData(fifoData), .fifoPop(fifoPop),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
        .reqLen(reqLen), .reqTag(reqTag), .reqLast(reqLast),
        .busy(busy), .descDone(descDone)
    );

    fifo_desc_reader #(.MAX_PAYLOAD_DW(MP2), .CNT_W(16)) u_dut512 (
        .clockCore(clk), .resetCore(resetCore), .enable(enable2),
        .fifoEmpty(fifoEmpty2), .fifoData(fifoData2), .fifoPop(fifoPop2),
        .reqValid(reqValid2), .reqReady(reqReady2), .reqAddr(reqAddr2),
        .reqLen(reqLen2), .reqTag(reqTag2), .reqLast(reqLast2),
        .busy(busy2), .descDone(descDone2)
    );

    typedef struct packed {
        logic [13:0] addr;
        logic [9:0]  len;
        logic [3:0]  tag;
        logic        last;
    } req_t;

    typedef struct {
        logic [27:0] desc;
        int          nreq;
        logic [13:0] a0;
        int          l0;
        logic [13:0] al;
        int          ll;
    } vec_t;

    req_t        exp_q[$];
    req_t        exp2_q[$];
    req_t        obs_q[$];
    logic [27:0] fifo_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, pops = 0, hs_cnt = 0, hs2_cnt = 0, done_cnt = 0;
    int first_hs_cyc = -1, last_hs_cyc = -1, last_pop_cyc = -1, gaps = 0;
    bit underrun = 1'b0, stall_prev = 1'b0;
    bit rand_ready = 1'b0, rand_en = 1'b0;
    req_t prev_req;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: split a descriptor by plain arithmetic.
    task automatic build_exp(input logic [27:0] d, input int mp, input bit second);
        int a, r, c;
        req_t t;
        a = int'(d[13:0]);
        r = (d[23:14] == 10'd0) ? 1024 : int'(d[23:14]);
        while (r > 0) begin
            c = r;
            if (mp < c) c = mp;
            if (1024 - (a % 1024) < c) c = 1024 - (a % 1024);
            t.addr = a[13:0];
            t.len  = c[9:0];
            t.tag  = d[27:24];
            t.last = (c == r);
            if (second) exp2_q.push_back(t); else exp_q.push_back(t);
            a = (a + c) % 16384;
            r = r - c;
        end
    endtask

    task automatic refresh();
        fifoEmpty = (fifo_q.size() == 0);
        fifoData  = (fifo_q.size() == 0) ? 28'd0 : fifo_q[0];
    endtask

    task automatic push_desc(input logic [27:0] d);
        fifo_q.push_back(d);
        build_exp(d, MP, 1'b0);
        refresh();
    endtask

    task automatic clear_track();
        pops = 0; hs_cnt = 0; gaps = 0;
        first_hs_cyc = -1; last_hs_cyc = -1; last_pop_cyc = -1;
        obs_q.delete();
    endtask

    // One clock: sample just after the falling edge, then advance.
    task automatic cycle();
        logic p, v, r, p2;
        req_t o, e;
        #1;
        p = fifoPop; v = reqValid; r = reqReady; p2 = fifoPop2;
        o = '{reqAddr, reqLen, reqTag, reqLast};
        chk(descDone == done_cnt[15:0], "descDone", 32'(descDone), 32'(done_cnt));
        if (stall_prev) chk(v && (o == prev_req), "stable_while_stalled", 32'(o), 32'(prev_req));
        if (p) begin
            pops++; last_pop_cyc = cyc;
            if (fifoEmpty) underrun = 1'b1;
        end
        if (v && r) begin
            hs_cnt++;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            if (last_hs_cyc >= 0 && cyc != last_hs_cyc + 1) gaps++;
            last_hs_cyc = cyc;
            obs_q.push_back(o);
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_req", 32'(o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk(o == e, "req", 32'(o), 32'(e));
            end
            if (o.last) done_cnt++;
        end
        stall_prev = v && !r;
        prev_req   = o;
        if (p2 && fifoEmpty2) underrun = 1'b1;
        if (reqValid2 && reqReady2) begin
            o = '{reqAddr2, reqLen2, reqTag2, reqLast2};
            hs2_cnt++;
            if (exp2_q.size() == 0) begin
                chk(1'b0, "unexpected_req512", 32'(o), 32'd0);
            end else begin
                e = exp2_q.pop_front();
                chk(o == e, "req512", 32'(o), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        if (!resetCore) begin
            done_cnt = 0; stall_prev = 1'b0;
        end
        if (p && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh();
        if (p2) fifoEmpty2 = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            if (rand_ready) reqReady = 1'($urandom_range(0, 1));
            if (rand_en) enable = ($urandom_range(0, 3) != 0);
            cycle();
            k++;
        end
        if (done_cnt < target) chk(1'b0, name, 32'(done_cnt), 32'(target));
    endtask

    vec_t tbl[5];

    initial begin
        int tgt, k, lasts, pushed;
        logic [27:0] d;
        req_t e;

        tbl[0] = '{{4'd5,  10'd100, 14'h0010},  4, 14'h0010, 32, 14'h0070,  4};
        tbl[1] = '{{4'd3,  10'd40,  14'h03F0},  2, 14'h03F0, 16, 14'h0400, 24};
        tbl[2] = '{{4'hA,  10'd0,   14'h3FE0}, 32, 14'h3FE0, 32, 14'h03C0, 32};
        tbl[3] = '{{4'd1,  10'd1,   14'h3FFF},  1, 14'h3FFF,  1, 14'h3FFF,  1};
        tbl[4] = '{{4'hF,  10'd33,  14'h0000},  2, 14'h0000, 32, 14'h0020,  1};

        resetCore = 1'b0; enable = 1'b0; reqReady = 1'b0;
        enable2 = 1'b0; reqReady2 = 1'b0; fifoEmpty2 = 1'b1; fifoData2 = 28'd0;
        refresh();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk(reqValid == 1'b0, "rst_reqValid", 32'(reqValid), 32'd0);
        chk(reqAddr == 14'd0, "rst_reqAddr", 32'(reqAddr), 32'd0);
        chk(reqLen == 10'd0, "rst_reqLen", 32'(reqLen), 32'd0);
        chk(reqTag == 4'd0, "rst_reqTag", 32'(reqTag), 32'd0);
        chk(reqLast == 1'b0, "rst_reqLast", 32'(reqLast), 32'd0);
        chk(busy == 1'b0, "rst_busy", 32'(busy), 32'd0);
        chk(descDone == 16'd0, "rst_descDone", 32'(descDone), 32'd0);
        @(negedge clk);
        resetCore = 1'b1;

        // Table: one descriptor at a time, ready held high.
        for (int i = 0; i < 5; i++) begin
            clear_track();
            enable = 1'b1; reqReady = 1'b1;
            push_desc(tbl[i].desc);
            run_until(done_cnt + 1, 100, "table_timeout");
            lasts = 0;
            foreach (obs_q[j]) if (obs_q[j].last) lasts++;
            chk(obs_q.size() == tbl[i].nreq, "tbl_nreq", 32'(obs_q.size()), 32'(tbl[i].nreq));
            if (obs_q.size() > 0) begin
                chk(obs_q[0].addr == tbl[i].a0, "tbl_first_addr", 32'(obs_q[0].addr), 32'(tbl[i].a0));
                chk(obs_q[0].len == tbl[i].l0[9:0], "tbl_first_len", 32'(obs_q[0].len), 32'(tbl[i].l0));
                chk(obs_q[$].addr == tbl[i].al, "tbl_last_addr", 32'(obs_q[$].addr), 32'(tbl[i].al));
                chk(obs_q[$].len == tbl[i].ll[9:0], "tbl_last_len", 32'(obs_q[$].len), 32'(tbl[i].ll));
                chk(obs_q[$].last == 1'b1, "tbl_last_flag", 32'(obs_q[$].last), 32'd1);
            end
            chk(lasts == 1, "tbl_single_last", 32'(lasts), 32'd1);
            chk(pops == 1, "tbl_pops", 32'(pops), 32'd1);
            chk(first_hs_cyc == last_pop_cyc + 1, "tbl_first_latency", 32'(first_hs_cyc), 32'(last_pop_cyc + 1));
            chk(gaps == 0, "tbl_no_idle", 32'(gaps), 32'd0);
            cycle(); cycle();
            chk(busy == 1'b0, "tbl_idle_busy", 32'(busy), 32'd0);
        end

        // Back-to-back with ready high: no idle cycles between descriptors.
        clear_track();
        for (int i = 0; i < 3; i++) push_desc({4'(i + 2), 10'd8, 14'($urandom) & 14'h3FF8});
        run_until(done_cnt + 3, 60, "b2b_timeout");
        chk(pops == 3, "b2b_pops", 32'(pops), 32'd3);
        chk(hs_cnt == 3, "b2b_reqs", 32'(hs_cnt), 32'd3);
        chk(gaps == 0, "b2b_no_idle", 32'(gaps), 32'd0);
        cycle();

        // Back-to-back under random backpressure.
        clear_track();
        for (int i = 0; i < 3; i++) push_desc({4'(i + 8), 10'd8, 14'($urandom) & 14'h3FF8});
        rand_ready = 1'b1;
        run_until(done_cnt + 3, 200, "bp_timeout");
        rand_ready = 1'b0; reqReady = 1'b1;
        chk(pops == 3, "bp_pops", 32'(pops), 32'd3);
        chk(hs_cnt == 3, "bp_reqs", 32'(hs_cnt), 32'd3);
        cycle();

        // Enable low holds the FIFO; raising it pops in the same cycle;
        // dropping it mid-descriptor does not stall the requests.
        clear_track();
        enable = 1'b0;
        push_desc({4'd4, 10'd64, 14'h0100});
        repeat (5) cycle();
        chk(pops == 0, "en_low_no_pop", 32'(pops), 32'd0);
        enable = 1'b1;
        #1;
        chk(fifoPop == 1'b1, "en_rise_pop", 32'(fifoPop), 32'd1);
        cycle();
        enable = 1'b0;
        run_until(done_cnt + 1, 20, "en_drop_timeout");
        chk(hs_cnt == 2, "en_drop_reqs", 32'(hs_cnt), 32'd2);
        enable = 1'b1;
        repeat (6) cycle();
        chk(pops == 1, "empty_no_pop", 32'(pops), 32'd1);
        chk(underrun == 1'b0, "no_underrun", 32'(underrun), 32'd0);

        // Reset during the 2nd of 4 requests.
        clear_track();
        push_desc({4'd6, 10'd128, 14'h0000});
        push_desc({4'd7, 10'd40, 14'h03F0});
        k = 0;
        while (hs_cnt < 1 && k < 20) begin cycle(); k++; end
        chk(hs_cnt == 1, "rst_reach_2nd", 32'(hs_cnt), 32'd1);
        resetCore = 1'b0; reqReady = 1'b0;
        cycle();
        chk(pops == 1, "rst_no_pop", 32'(pops), 32'd1);
        chk(reqValid == 1'b0, "rstmid_reqValid", 32'(reqValid), 32'd0);
        chk(busy == 1'b0, "rstmid_busy", 32'(busy), 32'd0);
        chk(descDone == 16'd0, "rstmid_descDone", 32'(descDone), 32'd0);
        // Drop what remains of the discarded descriptor.
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.last) break;
        end
        obs_q.delete();
        resetCore = 1'b1; reqReady = 1'b1;
        run_until(1, 30, "rst_resume_timeout");
        chk(obs_q.size() == 2, "rst_next_nreq", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() > 0) chk(obs_q[0].addr == 14'h03F0, "rst_next_start", 32'(obs_q[0].addr), 32'h3F0);

        // 512-DW payload instance: length 0 with address wrap.
        d = {4'd2, 10'd0, 14'h3FE0};
        build_exp(d, MP2, 1'b1);
        fifoData2 = d; fifoEmpty2 = 1'b0; enable2 = 1'b1; reqReady2 = 1'b1;
        k = 0;
        while (hs2_cnt < 3 && k < 20) begin cycle(); k++; end
        cycle();
        chk(hs2_cnt == 3, "mp512_nreq", 32'(hs2_cnt), 32'd3);
        chk(descDone2 == 16'd1, "mp512_done", 32'(descDone2), 32'd1);

        // Randomized descriptors, enable and ready.
        tgt = done_cnt + 20;
        pushed = 0; k = 0;
        rand_ready = 1'b1; rand_en = 1'b1;
        while (done_cnt < tgt && k < 5000) begin
            if (pushed < 20 && fifo_q.size() < 16 && $urandom_range(0, 2) == 0) begin
                d[27:24] = 4'($urandom);
                d[23:14] = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 200));
                d[13:0]  = 14'($urandom);
                push_desc(d);
                pushed++;
            end
            reqReady = 1'($urandom_range(0, 1));
            enable   = ($urandom_range(0, 3) != 0);
            cycle();
            k++;
        end
        rand_ready = 1'b0; rand_en = 1'b0;
        chk(done_cnt == tgt, "rand_done", 32'(done_cnt), 32'(tgt));
        chk(exp_q.size() == 0, "exp_drained", 32'(exp_q.size()), 32'd0);
        chk(exp2_q.size() == 0, "exp512_drained", 32'(exp2_q.size()), 32'd0);
        chk(underrun == 1'b0, "final_no_underrun", 32'(underrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_desc_reader.md
# fifo_desc_reader

Pop-side consumer for the 16-deep × 28-bit register FIFO (`GenRegFifo16D28W`) that queues DMA read descriptors. It drains one descriptor at a time from the FIFO head and splits it into read requests no larger than the maximum payload and never crossing a 1024-DW (4 KB) boundary. It presents those requests on a valid/ready interface to the PCIe request generator.

## Interface
- `MAX_PAYLOAD_DW`, 32: largest request length in DW; power of two, 1..512.
- `CNT_W`, 16: width of the completed-descriptor counter.
- `clockCore` in 1: core clock; everything is on the rising edge.
- `resetCore` in 1: synchronous, active-low reset.
- `enable` in 1: permits new descriptor pops; a descriptor already loaded always completes.
- `fifoEmpty` in 1: FIFO `empty`.
- `fifoData` in 28: FIFO `dataOut`. Show-ahead: holds the head entry whenever `fifoEmpty`=0.
- `fifoPop` out 1: FIFO `pop`; removes the head entry at the clock edge.
- `reqValid` out 1: a request is presented.
- `reqReady` in 1: the downstream side accepts the request.
- `reqAddr` out 14: DW start address of the request.
- `reqLen` out 10: request length in DW; 0 encodes 1024.
- `reqTag` out 4: descriptor tag.
- `reqLast` out 1: this is the final request of the descriptor.
- `busy` out 1: a descriptor is loaded and not yet complete.
- `descDone` out CNT_W: count of completed descriptors, wraps modulo 2^CNT_W.

## Operation
- Descriptor format in `fifoData`:
  - [27:24] tag
  - [23:14] length in DW; 0 means 1024
  - [13:0] start DW address
- FSM states are IDLE and ISSUE.
- **IDLE**
  - `fifoPop` = `enable` & ~`fifoEmpty`, combinational.
  - When `fifoPop`=1, the block captures tag, address and length (0 is expanded to 1024, held in 11 bits) and moves to ISSUE.
- **ISSUE**
  - Request length: chunk = min(remaining, MAX_PAYLOAD_DW, 1024 − addr[9:0]).
  - Outputs driven: `reqValid`=1, `reqAddr`=addr, `reqLen`=chunk[9:0], `reqTag`=tag, `reqLast`=(chunk==remaining).
  - On the handshake (`reqValid`&`reqReady`):
    - addr ← (addr + chunk) mod 2^14; the address wraps silently.
    - remaining ← remaining − chunk.
- **Last handshake in ISSUE**
  - `descDone` increments.
  - If `enable` & ~`fifoEmpty` in the same cycle, `fifoPop`=1, the next descriptor loads and the FSM stays in ISSUE. There is no bubble between descriptors.
  - Otherwise the FSM returns to IDLE.
- **Pop rules**
  - `fifoPop` is never asserted while `fifoEmpty`=1, so no underrun is possible.
  - `fifoPop` is never asserted in ISSUE except on the last-handshake cycle.
- **Output stability**: while `reqValid`=1 and `reqReady`=0, all `req*` outputs hold stable.
- **`enable` behaviour**: `enable` is sampled only at pop decisions. Dropping `enable` mid-descriptor does not stall the requests.
- **`busy`** = (state==ISSUE).
- **Reset** (`resetCore`=0 at an edge): FSM goes to IDLE. Any loaded descriptor is discarded. Reset values:
  - `reqValid`=0, `reqAddr`=0, `reqLen`=0, `reqTag`=0, `reqLast`=0
  - `busy`=0, `descDone`=0
  - `fifoPop`=0 while reset is asserted.

## Timing
- First request: `reqValid` rises 1 cycle after the edge at which `fifoPop`=1.
- Request cadence: a new request is available the cycle after each handshake. With `reqReady` held high, throughput is 1 request per cycle.
- Descriptor handoff: a back-to-back descriptor's first request follows its predecessor's last request by exactly 1 cycle.
- The `req*` outputs are registered. `fifoPop` is combinational from state, `enable`, `fifoEmpty`, `reqReady` and `reqLast`.

## Structure
- Shared package `dma_desc_pkg` holds:
  - field offsets and widths of the 28-bit descriptor
  - `BOUNDARY_DW`=1024
  - the FSM state enum
- A single sub-module `desc_chunk_calc` computes chunk and last from (addr, remaining); it is combinational.
- Top level: `fifo_desc_reader` contains the FSM and registers, with `desc_chunk_calc` instantiated inside.
- Integration: the integration wrapper connects the block to `GenRegFifo16D28W` (`pop`, `dataOut`, `empty`).

## Test plan
- **Basic split**: MAX_PAYLOAD_DW=32, descriptor {tag=5, len=100, addr=0x0010}, `reqReady`=1.
  - Requests are (0x0010,32), (0x0030,32), (0x0050,32), (0x0070,4).
  - Only the last request has `reqLast`=1.
  - `descDone` goes 0→1.
- **Boundary**: len=40, addr=0x03F0.
  - Requests are (0x03F0,16), (0x0400,24).
  - No request crosses bit 10.
- **Length 0 and address wrap**: len=0 (1024 DW), addr=0x3FE0, MAX_PAYLOAD_DW=512.
  - Requests are (0x3FE0,32), (0x0000,512), (0x0200,480).
  - The address wraps modulo 2^14.
- **Back-to-back and backpressure**:
  - Three 8-DW descriptors queued, `reqReady` toggling randomly: exactly 3 pops and 3 requests.
  - Outputs stay stable while stalled.
  - When `reqReady`=1 constantly, there are no idle cycles.
- **Enable and empty**: with `enable`=0 and the FIFO non-empty, no pop occurs. Raising `enable` pops on that same cycle. With the FIFO empty, `fifoPop` never asserts and FIFO `underrun` stays 0.
- **Reset mid-descriptor**: assert `resetCore`=0 during the 2nd of 4 requests.
  - Next cycle: `reqValid`=0, `busy`=0, `descDone`=0.
  - After release, the next FIFO entry is processed from its start.
